captura_teclado_rtc: RTL and testbench

CAPTURA_TECLADO_RTC -- requirements
Module: captura_teclado_rtc

---
 rtl/captura_teclado_rtc.sv | 256 +++++++++++++++++++++++++
 tb/tb_captura_teclado_rtc.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/captura_teclado_rtc.sv
// -----------------------------------------------------------------------------
// captura_teclado_rtc
//
// Keyboard capture front-end for setting a real-time clock. ASCII keys select
// a field ('H' hour, 'M' minute, 'S' second), then one or two decimal digits
// are typed and Enter commits the BCD value. The value is range-checked in
// the commit cycle; a valid value produces a one-cycle write strobe for the
// selected field, an invalid one produces error_tick. Escape aborts the
// entry, and an entry left open for TIMEOUT cycles without any key is
// aborted with error_tick.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous reset, active low
//   new_key_tick  one-cycle strobe, ascii_code is valid
//   ascii_code    ASCII code of the received key
//   edit_bcd      BCD value being edited ([7:4] tens, [3:0] units)
//   campo         field being edited: 00 none, 01 hour, 10 minute, 11 second
//   num_digitos   digits entered in the current entry (0..2)
//   dato_bcd      last committed BCD value (held between commits)
//   wr_hora       one-cycle commit strobe for the hour field
//   wr_min        one-cycle commit strobe for the minute field
//   wr_seg        one-cycle commit strobe for the second field
//   error_tick    one-cycle strobe: entry rejected (range or timeout)
// -----------------------------------------------------------------------------
module captura_teclado_rtc #(
  parameter int TIMEOUT = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_key_tick,
  input  logic [7:0] ascii_code,
  output logic [7:0] edit_bcd,
  output logic [1:0] campo,
  output logic [1:0] num_digitos,
  output logic [7:0] dato_bcd,
  output logic       wr_hora,
  output logic       wr_min,
  output logic       wr_seg,
  output logic       error_tick
);

  localparam int          CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAMPO,
    ST_DIG1,
    ST_DIG2,
    ST_COMMIT
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    campo_q, campo_d;
  logic [7:0]    edit_q, edit_d;
  logic [1:0]    num_q, num_d;
  logic [7:0]    dato_q, dato_d;
  logic          wr_hora_q, wr_hora_d;
  logic          wr_min_q, wr_min_d;
  logic          wr_seg_q, wr_seg_d;
  logic          error_q, error_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // Key classification
  // ---------------------------------------------------------------------------
  logic       key_field;
  logic [1:0] key_campo;
  logic       key_digit;
  logic       key_enter;
  logic       key_esc;

  always_comb begin
    key_field = 1'b0;
    key_campo = 2'b00;
    case (ascii_code)
      8'h48: begin key_field = 1'b1; key_campo = 2'b01; end
      8'h4D: begin key_field = 1'b1; key_campo = 2'b10; end
      8'h53: begin key_field = 1'b1; key_campo = 2'b11; end
      default: ;
    endcase
  end

  assign key_digit = (ascii_code >= 8'h30) && (ascii_code <= 8'h39);
  assign key_enter = (ascii_code == 8'h0D);
  assign key_esc   = (ascii_code == 8'h1B);

  // ---------------------------------------------------------------------------
  // Range check on the decimal value of the edited BCD pair
  // ---------------------------------------------------------------------------
  logic [6:0] edit_val;
  logic       in_range;

  assign edit_val = 7'(edit_q[7:4]) * 7'd10 + 7'(edit_q[3:0]);
  assign in_range = (campo_q == 2'b01) ? (edit_val <= 7'd23) : (edit_val <= 7'd59);

  // ---------------------------------------------------------------------------
  // Inactivity timeout. A key arriving on the expiry cycle takes priority.
  // ---------------------------------------------------------------------------
  logic entry_open;
  logic timeout_hit;

  assign entry_open  = (state_q == ST_CAMPO) || (state_q == ST_DIG1) || (state_q == ST_DIG2);
  assign timeout_hit = entry_open && !new_key_tick && (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    campo_d   = campo_q;
    edit_d    = edit_q;
    num_d     = num_q;
    dato_d    = dato_q;
    wr_hora_d = 1'b0;
    wr_min_d  = 1'b0;
    wr_seg_d  = 1'b0;
    error_d   = 1'b0;

    if (new_key_tick || (state_q == ST_IDLE) || timeout_hit) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        campo_d = 2'b00;
        edit_d  = 8'h00;
        num_d   = 2'd0;
        if (new_key_tick && key_field) begin
          state_d = ST_CAMPO;
          campo_d = key_campo;
        end
      end

      ST_CAMPO: begin
        if (new_key_tick) begin
          if (key_digit) begin
            state_d = ST_DIG1;
            edit_d  = {4'h0, ascii_code[3:0]};
            num_d   = 2'd1;
          end else if (key_field) begin
            campo_d = key_campo;
          end else if (key_enter || key_esc) begin
            state_d = ST_IDLE;
            campo_d = 2'b00;
            edit_d  = 8'h00;
            num_d   = 2'd0;
          end
        end
      end

      ST_DIG1, ST_DIG2: begin
        if (new_key_tick) begin
          if (key_digit) begin
            // First digit becomes tens; further digits only overwrite units.
            state_d = ST_DIG2;
            num_d   = 2'd2;
            if (state_q == ST_DIG1) begin
              edit_d = {edit_q[3:0], ascii_code[3:0]};
            end else begin
              edit_d = {edit_q[7:4], ascii_code[3:0]};
            end
          end else if (key_field) begin
            state_d = ST_CAMPO;
            campo_d = key_campo;
            edit_d  = 8'h00;
            num_d   = 2'd0;
          end else if (key_enter) begin
            state_d = ST_COMMIT;
          end else if (key_esc) begin
            state_d = ST_IDLE;
            campo_d = 2'b00;
            edit_d  = 8'h00;
            num_d   = 2'd0;
          end
        end
      end

      ST_COMMIT: begin
        // Keys arriving in this cycle are dropped.
        if (in_range) begin
          dato_d = edit_q;
          case (campo_q)
            2'b01:   wr_hora_d = 1'b1;
            2'b10:   wr_min_d  = 1'b1;
            2'b11:   wr_seg_d  = 1'b1;
            default: error_d   = 1'b1;
          endcase
        end else begin
          error_d = 1'b1;
        end
        state_d = ST_IDLE;
        campo_d = 2'b00;
        edit_d  = 8'h00;
        num_d   = 2'd0;
      end

      default: begin
        state_d = ST_IDLE;
        campo_d = 2'b00;
        edit_d  = 8'h00;
        num_d   = 2'd0;
      end
    endcase

    if (timeout_hit) begin
      state_d = ST_IDLE;
      campo_d = 2'b00;
      edit_d  = 8'h00;
      num_d   = 2'd0;
      error_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      campo_q   <= 2'b00;
      edit_q    <= 8'h00;
      num_q     <= 2'd0;
      dato_q    <= 8'h00;
      wr_hora_q <= 1'b0;
      wr_min_q  <= 1'b0;
      wr_seg_q  <= 1'b0;
      error_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      campo_q   <= campo_d;
      edit_q    <= edit_d;
      num_q     <= num_d;
      dato_q    <= dato_d;
      wr_hora_q <= wr_hora_d;
      wr_min_q  <= wr_min_d;
      wr_seg_q  <= wr_seg_d;
      error_q   <= error_d;
      cnt_q     <= cnt_d;
    end
  end

  assign edit_bcd    = edit_q;
  assign campo       = campo_q;
  assign num_digitos = num_q;
  assign dato_bcd    = dato_q;
  assign wr_hora     = wr_hora_q;
  assign wr_min      = wr_min_q;
  assign wr_seg      = wr_seg_q;
  assign error_tick  = error_q;

endmodule

// File: tb/tb_captura_teclado_rtc.sv
// -----------------------------------------------------------------------------
// tb_captura_teclado_rtc
//
// Drives directed and random key sequences into captura_teclado_rtc. A
// key-level reference model predicts the visible entry state after every edge
// and queues each expected strobe (kind, value, edge number); an independent
// monitor pops the queue whenever the DUT raises a strobe.
// -----------------------------------------------------------------------------
module tb_captura_teclado_rtc;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       new_key_tick = 1'b0;
  logic [7:0] ascii_code = 8'h00;
  logic [7:0] edit_bcd;
  logic [1:0] campo;
  logic [1:0] num_digitos;
  logic [7:0] dato_bcd;
  logic       wr_hora;
  logic       wr_min;
  logic       wr_seg;
  logic       error_tick;

  captura_teclado_rtc #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .new_key_tick (new_key_tick),
    .ascii_code   (ascii_code),
    .edit_bcd     (edit_bcd),
    .campo        (campo),
    .num_digitos  (num_digitos),
    .dato_bcd     (dato_bcd),
    .wr_hora      (wr_hora),
    .wr_min       (wr_min),
    .wr_seg       (wr_seg),
    .error_tick   (error_tick)
  );

  always #5 clk = ~clk;

  // kind: 0 error, 1 hour, 2 minute, 3 second
  typedef struct {
    int kind;
    int val;
    int at;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_no = 0;

  // Reference model: open field (0 = none), digits typed so far, edge of the
  // last key, and a pending commit scheduled for the edge after Enter.
  int m_field = 0;
  int m_digits[$];
  int m_last = 0;
  int m_commit_at = -1;
  int m_commit_ok = 0;
  int m_commit_val = 0;
  int m_dato = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, req, edge_no);
    end
  endtask

  function automatic int exp_edit();
    int t;
    int u;
    t = 0;
    u = 0;
    if (m_digits.size() == 2) t = m_digits[0];
    if (m_digits.size() >= 1) u = m_digits[m_digits.size()-1];
    return t * 16 + u;
  endfunction

  task automatic model_reset();
    m_field = 0;
    m_digits.delete();
    m_commit_at = -1;
    m_dato = 0;
    exp_q.delete();
  endtask

  task automatic model_key(input int code);
    int f;
    int v;
    int dec;
    int lim;
    f = 0;
    if (code == 'h48) f = 1;
    else if (code == 'h4D) f = 2;
    else if (code == 'h53) f = 3;
    if (f != 0) begin
      m_field = f;
      m_digits.delete();
    end else if (code >= 'h30 && code <= 'h39) begin
      if (m_field != 0) begin
        if (m_digits.size() < 2) m_digits.push_back(code - 'h30);
        else m_digits[1] = code - 'h30;
      end
    end else if (code == 'h0D) begin
      if (m_field != 0) begin
        if (m_digits.size() == 0) begin
          m_field = 0;
        end else begin
          v   = exp_edit();
          dec = (v / 16) * 10 + (v % 16);
          lim = (m_field == 1) ? 23 : 59;
          m_commit_at  = edge_no + 1;
          m_commit_ok  = (dec <= lim) ? 1 : 0;
          m_commit_val = v;
          exp_q.push_back('{(dec <= lim) ? m_field : 0, v, edge_no + 1});
        end
      end
    end else if (code == 'h1B) begin
      m_field = 0;
      m_digits.delete();
    end
  endtask

  task automatic model_edge(input bit tick, input int code);
    if (m_commit_at == edge_no) begin
      if (m_commit_ok != 0) m_dato = m_commit_val;
      m_field = 0;
      m_digits.delete();
      m_commit_at = -1;
    end else if (tick) begin
      m_last = edge_no;
      model_key(code);
    end else if (m_field != 0 && (edge_no - m_last) == TO) begin
      exp_q.push_back('{0, 0, edge_no});
      m_field = 0;
      m_digits.delete();
    end
  endtask

  task automatic check_outputs();
    chk("campo", int'(campo), m_field);
    chk("num_digitos", int'(num_digitos), m_digits.size());
    chk("edit_bcd", int'(edit_bcd), exp_edit());
    chk("dato_bcd", int'(dato_bcd), m_dato);
    if (!reset) chk("strobes_in_reset", int'({wr_hora, wr_min, wr_seg, error_tick}), 0);
  endtask

  task automatic step(input bit t, input logic [7:0] c);
    @(negedge clk);
    new_key_tick = t;
    ascii_code   = c;
    @(posedge clk);
    edge_no++;
    if (reset) model_edge(t, int'(c));
    #1;
    check_outputs();
  endtask

  task automatic key(input logic [7:0] c);
    step(1'b1, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  // Assert reset between edges and check that it acts without a clock edge.
  task automatic do_reset();
    #2 reset = 1'b0;
    model_reset();
    #1 check_outputs();
    idle(2);
    #2 reset = 1'b1;
  endtask

  // Strobe monitor / scoreboard consumer
  bit   prev_stb = 1'b0;
  exp_t mon_e;
  int   mon_n;
  int   mon_kind;

  always @(negedge clk) begin
    if (reset) begin
      mon_n = int'(wr_hora) + int'(wr_min) + int'(wr_seg) + int'(error_tick);
      if (mon_n != 0) begin
        chk("strobe_onehot", mon_n, 1);
        chk("strobe_gap", int'(prev_stb), 0);
        mon_kind = error_tick ? 0 : (wr_hora ? 1 : (wr_min ? 2 : 3));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL strobe_unexpected: got kind %0d at edge %0d, expected none", mon_kind, edge_no);
        end else begin
          mon_e = exp_q.pop_front();
          chk("strobe_kind", mon_kind, mon_e.kind);
          chk("strobe_edge", edge_no, mon_e.at);
          if (mon_kind != 0) chk("dato_at_wr", int'(dato_bcd), mon_e.val);
        end
      end
      while (exp_q.size() > 0 && exp_q[0].at < edge_no) begin
        mon_e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL strobe_missing: got none by edge %0d, expected kind %0d at edge %0d",
                 edge_no, mon_e.kind, mon_e.at);
      end
      prev_stb = (mon_n != 0);
    end else begin
      prev_stb = 1'b0;
    end
  end

  logic [7:0] fld [3] = '{8'h48, 8'h4D, 8'h53};

  initial begin
    int r;
    int gap;
    logic [7:0] c;

    #1 reset = 1'b0;
    model_reset();
    #1 check_outputs();
    idle(2);
    #2 reset = 1'b1;

    // Keys outside an entry are ignored
    key(8'h35); key(8'h0D); key(8'h1B); idle(1);

    // Basic commits and range limits
    key(8'h48); key(8'h31); key(8'h35); key(8'h0D); idle(2);
    key(8'h48); key(8'h32); key(8'h34); key(8'h0D); idle(2);
    key(8'h48); key(8'h32); key(8'h33); key(8'h0D); idle(2);
    key(8'h4D); key(8'h35); key(8'h39); key(8'h0D); idle(2);
    key(8'h4D); key(8'h36); key(8'h30); key(8'h0D); idle(2);
    key(8'h53); key(8'h37); key(8'h0D); idle(2);
    key(8'h53); key(8'h31); key(8'h32); key(8'h33); key(8'h0D); idle(2);

    // Enter in CAMPO aborts silently; key in the commit cycle is lost
    key(8'h4D); key(8'h0D); idle(1);
    key(8'h48); key(8'h31); key(8'h0D); key(8'h4D); idle(2);

    // Timeout: key on the expiry edge wins, then a real expiry
    key(8'h4D); key(8'h34); idle(TO - 1); key(8'h35); key(8'h1B); idle(1);
    key(8'h4D); key(8'h34); idle(TO); idle(2);

    // Reset mid-entry, then Escape abort
    key(8'h48); key(8'h31); do_reset(); key(8'h0D); idle(1);
    key(8'h4D); key(8'h30); key(8'h1B); idle(2);

    // Ignored code, field switch, held tick
    key(8'h4D); key(8'h33); key(8'h41); key(8'h48); key(8'h30); key(8'h38); key(8'h0D); idle(2);
    key(8'h48); key(8'h35); key(8'h35); key(8'h35); key(8'h1B); idle(2);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) gap = $urandom_range(TO - 2, TO + 3);
      else if (r < 8) gap = 0;
      else gap = $urandom_range(1, 3);
      idle(gap);
      r = $urandom_range(0, 99);
      if (r < 15) c = fld[$urandom_range(0, 2)];
      else if (r < 60) c = 8'(8'h30 + $urandom_range(0, 9));
      else if (r < 75) c = 8'h0D;
      else if (r < 82) c = 8'h1B;
      else c = 8'($urandom_range(0, 255));
      key(c);
    end

    idle(TO + 4);
    chk("pending_expected", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by time limit, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
